// File: rtl/io_port_arbiter_if.sv
// io_port_arbiter_if: requester handshake and IO port bus signals of io_port_arbiter.
// slave is the arbiter side; master is the requester/bus-model side.
interface io_port_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_write;
   logic [NUM_REQ*8-1:0] req_port_id;
   logic [NUM_REQ*8-1:0] req_wdata;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [7:0]           rsp_rdata;
   logic [7:0]           IO_port_ID;
   logic [7:0]           IO_write_data;
   logic                 IO_write_strobe;
   logic                 IO_read_strobe;
   logic [7:0]           IO_read_data;
   logic                 busy;
   modport slave (
      input  req_valid, req_write, req_port_id, req_wdata, IO_read_data,
      output req_ready, rsp_valid, rsp_rdata, IO_port_ID, IO_write_data,
             IO_write_strobe, IO_read_strobe, busy
   );
   modport master (
      output req_valid, req_write, req_port_id, req_wdata, IO_read_data,
      input  req_ready, rsp_valid, rsp_rdata, IO_port_ID, IO_write_data,
             IO_write_strobe, IO_read_strobe, busy
   );
endinterface

// File: rtl/io_port_arbiter.sv
// io_port_arbiter: round-robin sharing of one 8-bit IO port bus among NUM_REQ requesters,
// one strobe per transaction, read data returned RD_LATENCY cycles after the strobe.
module io_port_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int RD_LATENCY = 1
) (
   input logic              clk,
   input logic              reset,
   io_port_arbiter_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d, win;
   logic [7:0]         id_q, id_d, wd_q, wd_d, rd_q, rd_d;
   logic               wr_q, wr_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0] ready, rsp;
   // Scan downward so the nearest valid requester after p overwrites any farther one.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] p);
      logic [IW-1:0] idx;
      rr_pick = p;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IW'((int'(p) + k) % NUM_REQ);
         if (v[idx]) rr_pick = idx;
      end
   endfunction
   assign win = rr_pick(bus.req_valid, ptr_q);
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      wd_d    = wd_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      ready   = '0;
      rsp     = '0;
      case (state_q)
         IDLE: if (|bus.req_valid) begin
            ready[win] = reset;
            ptr_d      = win;
            id_d       = bus.req_port_id[{win, 3'b000} +: 8];
            wd_d       = bus.req_wdata[{win, 3'b000} +: 8];
            wr_d       = bus.req_write[win];
            state_d    = ISSUE;
         end
         ISSUE: begin
            if (wr_q) state_d = IDLE;
            else if (RD_LATENCY == 0) begin
               rd_d    = bus.IO_read_data;
               state_d = CAPTURE;
            end else begin
               cnt_d   = 3'(RD_LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               rd_d    = bus.IO_read_data;
               state_d = CAPTURE;
            end
         end
         default: begin
            rsp[ptr_q] = 1'b1;
            state_d    = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NUM_REQ - 1);
         id_q    <= '0;
         wd_q    <= '0;
         wr_q    <= 1'b0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         wd_q    <= wd_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.req_ready       = ready;
   assign bus.rsp_valid       = rsp;
   assign bus.rsp_rdata       = rd_q;
   assign bus.IO_port_ID      = id_q;
   assign bus.IO_write_data   = wd_q;
   assign bus.IO_write_strobe = (state_q == ISSUE) && wr_q;
   assign bus.IO_read_strobe  = (state_q == ISSUE) && !wr_q;
   assign bus.busy            = state_q != IDLE;
endmodule

// File: tb/tb_io_port_arbiter.sv
// tb_io_port_arbiter: random requesters on three arbiter configurations, checked each cycle
// against a transaction-schedule model (accept cycle -> strobe, sample, response, idle cycles).
module tb_io_port_arbiter;
   localparam int CYCLES = 3000;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask
   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int NR = (g == 2) ? 4 : 2;
      localparam int RL = (g == 0) ? 0 : (g == 1) ? 1 : 3;
      logic            rst_n;
      logic [NR-1:0]   v, wr;
      logic [8*NR-1:0] pid, pwd;
      logic [7:0]      rdin;
      io_port_arbiter_if #(.NUM_REQ(NR)) bus();
      io_port_arbiter #(.NUM_REQ(NR), .RD_LATENCY(RL)) dut (.clk(clk), .reset(rst_n), .bus(bus));
      assign bus.req_valid    = v;
      assign bus.req_write    = wr;
      assign bus.req_port_id  = pid;
      assign bus.req_wdata    = pwd;
      assign bus.IO_read_data = rdin;
      initial begin
         int ptr, own, free_at, stb_at, smp_at, rsp_at, w_exp, last_acc, rst_cnt;
         logic cur_wr;
         logic [7:0] m_id, m_wd, m_rd;
         logic [NR-1:0] rdy_exp, rsp_exp;
         bit idle, mid;
         rst_n = 1'b0; v = '0; wr = '0; pid = '0; pwd = '0; rdin = '0;
         ptr = NR - 1; own = 0; free_at = 0; stb_at = -1; smp_at = -1; rsp_at = -1;
         last_acc = -1; rst_cnt = 3; cur_wr = 1'b0; m_id = '0; m_wd = '0; m_rd = '0;
         for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #1;
            // Reset pulses: periodic, plus random ones landing while a read is waiting.
            mid = !cur_wr && stb_at < c && c <= smp_at;
            if (rst_cnt > 0) begin
               rst_cnt--;
               rst_n = (rst_cnt == 0);
            end else if ((c % 311) == 200 || (mid && $urandom_range(0, 7) == 0)) begin
               rst_n   = 1'b0;
               rst_cnt = 2;
            end
            for (int i = 0; i < NR; i++) begin
               if (last_acc == i) begin
                  v[i] = 1'($urandom_range(0, 1));
                  wr[i] = 1'($urandom);
                  pid[8*i +: 8] = 8'($urandom);
                  pwd[8*i +: 8] = 8'($urandom);
               end else if (v[i]) begin
                  if ($urandom_range(0, 7) == 0) v[i] = 1'b0;
               end else if ($urandom_range(0, 1) == 1) begin
                  v[i] = 1'b1;
                  wr[i] = 1'($urandom);
                  pid[8*i +: 8] = 8'($urandom);
                  pwd[8*i +: 8] = 8'($urandom);
               end
            end
            rdin = 8'($urandom);
            @(negedge clk);
            if (!rst_n) begin
               ptr = NR - 1; free_at = c; stb_at = -1; smp_at = -1; rsp_at = -1;
               cur_wr = 1'b0; m_id = '0; m_wd = '0; m_rd = '0;
            end
            idle = c >= free_at;
            w_exp = -1;
            if (idle && rst_n)
               for (int k = 1; k <= NR && w_exp < 0; k++)
                  if (v[(ptr + k) % NR]) w_exp = (ptr + k) % NR;
            rdy_exp = '0;
            if (w_exp >= 0) rdy_exp[w_exp] = 1'b1;
            rsp_exp = '0;
            if (c == rsp_at) rsp_exp[own] = 1'b1;
            check($sformatf("cfg%0d req_ready", g), 32'(bus.req_ready), 32'(rdy_exp));
            check($sformatf("cfg%0d rsp_valid", g), 32'(bus.rsp_valid), 32'(rsp_exp));
            check($sformatf("cfg%0d rsp_rdata", g), 32'(bus.rsp_rdata), 32'(m_rd));
            check($sformatf("cfg%0d IO_port_ID", g), 32'(bus.IO_port_ID), 32'(m_id));
            check($sformatf("cfg%0d IO_write_data", g), 32'(bus.IO_write_data), 32'(m_wd));
            check($sformatf("cfg%0d IO_write_strobe", g), 32'(bus.IO_write_strobe), 32'(c == stb_at && cur_wr));
            check($sformatf("cfg%0d IO_read_strobe", g), 32'(bus.IO_read_strobe), 32'(c == stb_at && !cur_wr));
            check($sformatf("cfg%0d busy", g), 32'(bus.busy), 32'(!idle));
            if (rst_n) begin
               if (c == smp_at) m_rd = rdin;
               if (w_exp >= 0) begin
                  own = w_exp; ptr = w_exp; cur_wr = wr[w_exp];
                  m_id = pid[8*w_exp +: 8]; m_wd = pwd[8*w_exp +: 8];
                  stb_at  = c + 1;
                  smp_at  = cur_wr ? -1 : c + 1 + RL;
                  rsp_at  = cur_wr ? -1 : c + 2 + RL;
                  free_at = cur_wr ? c + 2 : c + 3 + RL;
               end
            end
            last_acc = w_exp;
         end
      end
   end
   initial begin
      repeat (CYCLES + 5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_port_arbiter.md
Name: io_port_arbiter

Overview:
- Shares the single 8-bit IO port bus (IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe, IO_read_data) between NUM_REQ requesters. Typical requesters are the processor core's MEM/WB IO path and an auxiliary host/debug master.
- Round-robin arbitration with a valid/ready request handshake.
- Issues exactly one strobe per transaction.
- Returns read data after a fixed, parameterised bus read latency.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RD_LATENCY, 1, cycles from the read-strobe cycle to the edge on which IO_read_data is sampled (0..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transaction request.
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_port_id  in  NUM_REQ*8  port ID; requester i occupies bits [8i+7:8i].
- req_wdata  in  NUM_REQ*8  write data, same packing.
- req_ready  out  NUM_REQ  one-hot grant; a transaction is accepted on a cycle with valid&ready.
- rsp_valid  out  NUM_REQ  one-cycle, one-hot pulse signalling read completion.
- rsp_rdata  out  8  read data, shared by all requesters.
- IO_port_ID  out  8  port ID to the IO bus.
- IO_write_data  out  8  write data to the IO bus.
- IO_write_strobe  out  1  one-cycle write strobe.
- IO_read_strobe  out  1  one-cycle read strobe.
- IO_read_data  in  8  read data from the IO bus.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: req_ready, rsp_valid, rsp_rdata, IO_port_ID, IO_write_data, both strobes, busy.
  - RR pointer goes to NUM_REQ-1, so requester 0 has highest priority first.
  - A read in flight is dropped; no rsp_valid is ever produced for it.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - Winner w = first requester with req_valid set, searching from ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[w] is driven combinationally in the same cycle; only in IDLE; at most one bit set.
  - On accept: register the port ID, wdata, write flag and w; set ptr=w; go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - IO_port_ID and IO_write_data are driven from registers. The matching strobe is high; the other strobe stays 0.
  - Write: next state IDLE.
  - Read with RD_LATENCY=0: sample IO_read_data at the end of this cycle; next state CAPTURE.
  - Read with RD_LATENCY>0: load the wait counter with RD_LATENCY; next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, sample IO_read_data at that cycle's edge; next state CAPTURE.
- CAPTURE (1 cycle):
  - rsp_valid[w]=1 and rsp_rdata holds the sampled value.
  - Next state IDLE.
- Timing summary:
  - Write: strobe in the cycle after accept. Throughput is 1 write per 2 cycles.
  - Read: strobe at cycle T. Data is sampled at the end of cycle T+RD_LATENCY. rsp_valid is high in cycle T+RD_LATENCY+1.
  - A new accept is possible in the cycle after CAPTURE.
- Held values:
  - rsp_rdata keeps its value until the next read completes.
  - IO_port_ID and IO_write_data keep the last issued values between transactions; they are not cleared on return to IDLE.
  - IO_write_data is also driven on reads and holds the registered wdata, which is don't-care to the bus.
- Requester rules:
  - req_valid may drop without being granted; there is no side effect.
  - Payload must be stable while valid is high and not yet ready. Payload is sampled only on the accept edge; later changes do not affect the issued transaction.
  - A requester may re-request while its own read is outstanding. It is not granted until the FSM returns to IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,… with no requester skipped.
- busy = (state != IDLE).
- Invariants:
  - The two strobes are never high simultaneously.
  - Never more than one transaction is outstanding.

Test Plan:
1. Reset and single write: reset low mid-stream, then high. Req0 writes id=0x12, data=0xA5 → req_ready[0] in accept cycle C; IO_write_strobe=1, IO_port_ID=0x12, IO_write_data=0xA5 only in C+1; IO_read_strobe stays 0; busy=1 in C+1 only.
2. Read latency sweep, RD_LATENCY ∈ {0,1,3}: req1 reads id=0x40, bus model returns 0x3C sampled RD_LATENCY cycles after the strobe → rsp_valid[1] one pulse at strobe+RD_LATENCY+1, rsp_rdata=0x3C; rsp_valid[0] stays 0.
3. Contention, NUM_REQ=2: both requesters hold valid writes continuously for 6 transactions → grants in order 0,1,0,1,0,1, strobes every 2nd cycle, each carrying the correct id/data.
4. Fairness, NUM_REQ=4: req3 and req1 valid after a req2 grant → next grant 3, then 1; no grant while a requester's valid is low.
5. Reset mid-read: RD_LATENCY=3, assert reset during WAIT → all outputs 0 immediately; no rsp_valid afterwards; next request is granted with RR starting from requester 0.
6. Payload stability and back-to-back: req0 read completes with rsp_rdata=0x77; change req_port_id after accept, then issue a req0 write in the cycle after CAPTURE → the issued read used the original id; the write is accepted immediately; rsp_rdata remains 0x77.
